// File: rtl/adder_serial_n.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes, DIGIT bits per cycle, LSD first.
// Optional feature: define ADDER_SERIAL_OVF_EN to build signed-overflow detection; otherwise ovf is tied to 0.
module adder_serial_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;

  logic [DIGIT-1:0] a_dig [NDIG];
  logic [DIGIT-1:0] b_dig [NDIG];
  logic [DIGIT-1:0] a_cur;
  logic [DIGIT-1:0] b_cur;
  logic [DIGIT:0]   dig_add;
  logic             last_dig;
  logic             run_step;
  logic             accept;

  // Slice the latched operands into digits so the active one is a plain mux.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
    assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
    assign sum_next[gi*DIGIT +: DIGIT] =
      (run_step && (cnt_reg == CW'(gi))) ? dig_add[DIGIT-1:0] : sum_reg[gi*DIGIT +: DIGIT];
  end

  assign a_cur    = a_dig[cnt_reg];
  assign b_cur    = b_dig[cnt_reg];
  assign dig_add  = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_reg};
  assign last_dig = (cnt_reg == CW'(NDIG - 1));
  assign run_step = (state_reg == RUN);
  assign accept   = (state_reg == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_dig) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      sum_reg <= sum_next;
      if (accept) begin
        // Subtraction is A + ~B + 1, so invert B once here and seed the carry.
        a_reg     <= a;
        b_reg     <= sub ? ~b : b;
        carry_reg <= sub ? 1'b1 : cin;
        cnt_reg   <= '0;
      end else if (run_step) begin
        carry_reg <= dig_add[DIGIT];
        if (last_dig) cout_reg <= dig_add[DIGIT];
        else          cnt_reg  <= cnt_reg + CW'(1);
      end
    end
  end

`ifdef ADDER_SERIAL_OVF_EN
  logic msb_carry_reg;
  logic msb_carry;
  logic ovf_reg;

  // Carry into the MSB is recovered from the MSB sum bit of the final digit.
  assign msb_carry = a_cur[DIGIT-1] ^ b_cur[DIGIT-1] ^ dig_add[DIGIT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      msb_carry_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (run_step && last_dig) begin
      msb_carry_reg <= msb_carry;
      ovf_reg       <= msb_carry ^ dig_add[DIGIT];
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_adder_serial_n.sv
// Randomized and directed bench for adder_serial_n against an arithmetic reference model.
module tb_adder_serial_n;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  adder_serial_n #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic ci, input logic sb);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             ov;
    bb   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
`ifdef ADDER_SERIAL_OVF_EN
    ov = (av[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
`else
    ov = 1'b0;
`endif
    return {ov, full};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, input logic sb, input int hold);
    logic [WIDTH+1:0] e;
    int lat;
    e = model(av, bv, ci, sb);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 4 * NDIG + 4) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(NDIG));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(e[WIDTH-1:0]));
    end
    check("sum", 32'(sum), 32'(e[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(e[WIDTH]));
    check("ovf", 32'(ovf), 32'(e[WIDTH+1]));
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d (exp %h %0d %0d) lat=%0d",
             av, bv, ci, sb, sum, cout, ovf, e[WIDTH-1:0], e[WIDTH], e[WIDTH+1], lat);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 3);

    // Abort an operation with carries pending during its 2nd RUN cycle.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
